io_serdes_bridge: RTL and testbench

Parametrised pad-to-core bridge between the chip's pad-cell ring and the core, generalising the flat one-pad-per-bit IO scheme. It lets a wide core input/output word cross a narrow pad bus.
- Input path: assembles CORE_IN_W-bit words from PAD_IN_W-bit pad beats.
- Output path: serialises CORE_OUT_W-bit core words into PAD_OUT_W-bit pad beats.
Both paths use handshakes and back-pressure.

---
 rtl/io_serdes_bridge_pkg.sv | 26 ++
 rtl/io_serdes_bridge_if.sv | 42 ++++
 rtl/io_serdes_out_shifter.sv | 103 ++++++++++
 rtl/io_serdes_bridge.sv | 110 +++++++++++
 tb/tb_io_serdes_bridge.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/io_serdes_bridge_pkg.sv
// io_serdes_bridge_pkg
// Shared constants, FSM state types and a counter-width helper for the
// pad-to-core serdes bridge.
//   PAD_IN_W / PAD_OUT_W / IO_OPCODE_L : default pad beat and opcode widths
//   CORE_IN_W / CORE_OUT_W             : default core word widths
//   BEATS_IN / BEATS_OUT               : beats per core word for the defaults
package io_serdes_bridge_pkg;

  localparam int PAD_IN_W    = 8;
  localparam int CORE_IN_W   = 32;
  localparam int PAD_OUT_W   = 8;
  localparam int CORE_OUT_W  = 32;
  localparam int IO_OPCODE_L = 4;

  localparam int BEATS_IN  = CORE_IN_W / PAD_IN_W;
  localparam int BEATS_OUT = CORE_OUT_W / PAD_OUT_W;

  typedef enum logic [1:0] {IN_IDLE, IN_COLLECT, IN_HOLD} in_fsm_t;
  typedef enum logic       {OUT_IDLE, OUT_SHIFT}           out_fsm_t;

  // Bits needed to index n beats; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_serdes_bridge_if.sv
// io_serdes_bridge_if
// Pad-side and core-side handshake bundle of the serdes bridge.
//   slave  : the bridge's view (consumes pad input beats and core output words)
//   master : the surrounding pad ring / core view
interface io_serdes_bridge_if
  import io_serdes_bridge_pkg::*;
#(
  parameter int PAD_IN_W   = io_serdes_bridge_pkg::PAD_IN_W,
  parameter int CORE_IN_W  = io_serdes_bridge_pkg::CORE_IN_W,
  parameter int PAD_OUT_W  = io_serdes_bridge_pkg::PAD_OUT_W,
  parameter int CORE_OUT_W = io_serdes_bridge_pkg::CORE_OUT_W,
  parameter int OPCODE_W   = io_serdes_bridge_pkg::IO_OPCODE_L
);
  logic [PAD_IN_W-1:0]   in_pad_data;
  logic [OPCODE_W-1:0]   in_pad_opcode;
  logic                  in_pad_valid;
  logic                  in_pad_busy;
  logic [CORE_IN_W-1:0]  in_core_data;
  logic [OPCODE_W-1:0]   in_core_opcode;
  logic                  in_core_valid;
  logic                  in_core_ready;
  logic [CORE_OUT_W-1:0] out_core_data;
  logic                  out_core_valid;
  logic                  out_core_ready;
  logic [PAD_OUT_W-1:0]  out_pad_data;
  logic                  out_pad_valid;
  logic                  out_pad_last;

  modport slave (
    input  in_pad_data, in_pad_opcode, in_pad_valid, in_core_ready,
    input  out_core_data, out_core_valid,
    output in_pad_busy, in_core_data, in_core_opcode, in_core_valid,
    output out_core_ready, out_pad_data, out_pad_valid, out_pad_last
  );

  modport master (
    output in_pad_data, in_pad_opcode, in_pad_valid, in_core_ready,
    output out_core_data, out_core_valid,
    input  in_pad_busy, in_core_data, in_core_opcode, in_core_valid,
    input  out_core_ready, out_pad_data, out_pad_valid, out_pad_last
  );
endinterface

// File: rtl/io_serdes_out_shifter.sv
// io_serdes_out_shifter
// Serialises one CORE_OUT_W word into BEATS_OUT pad beats, LSB-first.
// Optional macro IO_SERDES_OUT_PARITY_EN adds o_pad_parity.
//   clk, i_clr            : clock, synchronous clear (reset or flush)
//   i_core_data/_valid    : word offered by the core
//   o_core_ready          : high while idle
//   o_pad_data/_valid/_last : registered beat stream, data 0 when not valid
//   o_pad_parity          : XOR of o_pad_data (only with the macro)
module io_serdes_out_shifter
  import io_serdes_bridge_pkg::*;
#(
  parameter int PAD_OUT_W  = io_serdes_bridge_pkg::PAD_OUT_W,
  parameter int CORE_OUT_W = io_serdes_bridge_pkg::CORE_OUT_W
) (
  input  logic                  clk,
  input  logic                  i_clr,
  input  logic [CORE_OUT_W-1:0] i_core_data,
  input  logic                  i_core_valid,
  output logic                  o_core_ready,
  output logic [PAD_OUT_W-1:0]  o_pad_data,
  output logic                  o_pad_valid,
`ifdef IO_SERDES_OUT_PARITY_EN
  output logic                  o_pad_parity,
`endif
  output logic                  o_pad_last
);
  localparam int N_OUT = CORE_OUT_W / PAD_OUT_W;
  localparam int CW    = cnt_w(N_OUT);

  out_fsm_t              r_st, w_nxt;
  logic [CORE_OUT_W-1:0] r_shift;
  logic [CW-1:0]         r_cnt;   // index of the beat to emit next
  logic [PAD_OUT_W-1:0]  r_pad_d;
  logic                  r_pad_v, r_last, r_par;
  logic                  w_cap, w_beat_v, w_beat_last;
  logic [PAD_OUT_W-1:0]  w_beat_d;

  always_ff @(posedge clk) begin
    if (i_clr) r_st <= OUT_IDLE;
    else       r_st <= w_nxt;
  end

  always_comb begin
    w_nxt       = r_st;
    w_cap       = 1'b0;
    w_beat_v    = 1'b0;
    w_beat_d    = '0;
    w_beat_last = 1'b0;
    case (r_st)
      OUT_IDLE: if (i_core_valid) begin
        w_cap       = 1'b1;
        w_nxt       = OUT_SHIFT;
        w_beat_v    = 1'b1;
        w_beat_d    = i_core_data[PAD_OUT_W-1:0];
        w_beat_last = (N_OUT == 1);
      end
      OUT_SHIFT: begin
        if (r_last) w_nxt = OUT_IDLE;
        else begin
          w_beat_v    = 1'b1;
          w_beat_d    = r_shift[PAD_OUT_W-1:0];
          w_beat_last = (r_cnt == CW'(N_OUT - 1));
        end
      end
      default: w_nxt = OUT_IDLE;
    endcase
  end

  // beat register stage
  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_pad_d <= '0;
      r_pad_v <= 1'b0;
      r_last  <= 1'b0;
      r_par   <= 1'b0;
    end else begin
      r_pad_v <= w_beat_v;
      r_pad_d <= w_beat_d;
      r_last  <= w_beat_last;
      r_par   <= ^w_beat_d;
      if (w_cap) begin
        r_shift <= i_core_data >> PAD_OUT_W;
        r_cnt   <= CW'(1);
      end else if (w_beat_v) begin
        r_shift <= r_shift >> PAD_OUT_W;
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end

  assign o_core_ready = (r_st == OUT_IDLE);
  assign o_pad_data   = r_pad_d;
  assign o_pad_valid  = r_pad_v;
  assign o_pad_last   = r_last;
`ifdef IO_SERDES_OUT_PARITY_EN
  assign o_pad_parity = r_par;
`else
  logic w_par_unused;
  assign w_par_unused = r_par;
`endif
endmodule

// File: rtl/io_serdes_bridge.sv
// io_serdes_bridge
// Pad-to-core bridge: assembles CORE_IN_W words from PAD_IN_W pad beats
// (LSB-first) and serialises CORE_OUT_W core words into PAD_OUT_W beats.
// Optional macro IO_SERDES_OUT_PARITY_EN adds out_pad_parity.
//   clk, rst            : clock, synchronous active-high reset
//   reset_execution_io  : soft flush of both paths (keeps err_overflow)
//   bus (slave)         : pad/core handshakes, see io_serdes_bridge_if
//   err_overflow        : sticky, a pad beat arrived while busy
//   out_pad_parity      : even parity of out_pad_data (only with the macro)
module io_serdes_bridge
  import io_serdes_bridge_pkg::*;
#(
  parameter int PAD_IN_W   = io_serdes_bridge_pkg::PAD_IN_W,
  parameter int CORE_IN_W  = io_serdes_bridge_pkg::CORE_IN_W,
  parameter int PAD_OUT_W  = io_serdes_bridge_pkg::PAD_OUT_W,
  parameter int CORE_OUT_W = io_serdes_bridge_pkg::CORE_OUT_W,
  parameter int OPCODE_W   = io_serdes_bridge_pkg::IO_OPCODE_L
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reset_execution_io,
  io_serdes_bridge_if.slave   bus,
`ifdef IO_SERDES_OUT_PARITY_EN
  output logic                out_pad_parity,
`endif
  output logic                err_overflow
);
  localparam int N_IN = CORE_IN_W / PAD_IN_W;
  localparam int CW   = cnt_w(N_IN);

  if ((PAD_IN_W < 1) || (CORE_IN_W < PAD_IN_W) || ((CORE_IN_W % PAD_IN_W) != 0)) begin : g_bad_in
    $error("CORE_IN_W must be a non-zero multiple of PAD_IN_W");
  end
  if ((PAD_OUT_W < 1) || (CORE_OUT_W < PAD_OUT_W) || ((CORE_OUT_W % PAD_OUT_W) != 0)) begin : g_bad_out
    $error("CORE_OUT_W must be a non-zero multiple of PAD_OUT_W");
  end

  logic                 w_clr;
  in_fsm_t              r_in_st, w_in_nxt;
  logic [CW-1:0]        r_in_cnt;
  logic [CORE_IN_W-1:0] r_in_data;
  logic [OPCODE_W-1:0]  r_in_op;
  logic                 r_busy, r_err, w_accept, w_last_beat;

  assign w_clr       = rst | reset_execution_io;
  assign w_accept    = bus.in_pad_valid & ~r_busy;
  assign w_last_beat = (r_in_cnt == CW'(N_IN - 1));

  always_ff @(posedge clk) begin
    if (w_clr) r_in_st <= IN_IDLE;
    else       r_in_st <= w_in_nxt;
  end

  always_comb begin
    w_in_nxt = r_in_st;
    case (r_in_st)
      IN_IDLE:    if (w_accept) w_in_nxt = (N_IN == 1) ? IN_HOLD : IN_COLLECT;
      IN_COLLECT: if (w_accept && w_last_beat) w_in_nxt = IN_HOLD;
      IN_HOLD:    if (bus.in_core_ready) w_in_nxt = IN_IDLE;
      default:    w_in_nxt = IN_IDLE;
    endcase
  end

  // assembly stage: busy/valid are registered copies of "next state is HOLD"
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_in_cnt  <= '0;
      r_in_data <= '0;
      r_in_op   <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= (w_in_nxt == IN_HOLD);
      if (w_accept) begin
        r_in_cnt <= w_last_beat ? '0 : r_in_cnt + CW'(1);
        if (r_in_st == IN_IDLE) r_in_op <= bus.in_pad_opcode;
        for (int k = 0; k < N_IN; k++)
          if (r_in_cnt == CW'(k)) r_in_data[k*PAD_IN_W +: PAD_IN_W] <= bus.in_pad_data;
      end
    end
  end

  // Overflow survives the soft flush; only a hard reset clears it.
  always_ff @(posedge clk) begin
    if (rst)                            r_err <= 1'b0;
    else if (bus.in_pad_valid && r_busy) r_err <= 1'b1;
  end

  assign bus.in_pad_busy    = r_busy;
  assign bus.in_core_valid  = r_busy;
  assign bus.in_core_data   = r_in_data;
  assign bus.in_core_opcode = r_in_op;
  assign err_overflow       = r_err;

  io_serdes_out_shifter #(
    .PAD_OUT_W  (PAD_OUT_W),
    .CORE_OUT_W (CORE_OUT_W)
  ) u_out (
    .clk          (clk),
    .i_clr        (w_clr),
    .i_core_data  (bus.out_core_data),
    .i_core_valid (bus.out_core_valid),
    .o_core_ready (bus.out_core_ready),
    .o_pad_data   (bus.out_pad_data),
    .o_pad_valid  (bus.out_pad_valid),
`ifdef IO_SERDES_OUT_PARITY_EN
    .o_pad_parity (out_pad_parity),
`endif
    .o_pad_last   (bus.out_pad_last)
  );
endmodule

// File: tb/tb_io_serdes_bridge.sv
// tb_io_serdes_bridge
// Randomised and directed stimulus for io_serdes_bridge (8 -> 32 defaults),
// compared each cycle against a word/beat-queue reference model.
module tb_io_serdes_bridge;
  import io_serdes_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, err;
`ifdef IO_SERDES_OUT_PARITY_EN
  logic par;
`endif
  always #5 clk = ~clk;

  io_serdes_bridge_if bus ();

  io_serdes_bridge dut (
    .clk                (clk),
    .rst                (rst),
    .reset_execution_io (flush),
    .bus                (bus),
`ifdef IO_SERDES_OUT_PARITY_EN
    .out_pad_parity     (par),
`endif
    .err_overflow       (err)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: values expected in the current cycle.
  bit          m_busy, m_err, m_cur_v;
  logic [31:0] m_word, m_acc;
  logic [3:0]  m_op;
  int          m_nb;
  logic [8:0]  m_cur;      // {last, data} of the beat on the pads now
  logic [8:0]  m_q[$];     // beats still to come

  function automatic bit m_ready();
    return !m_cur_v && (m_q.size() == 0);
  endfunction

  task automatic model_clear();
    m_busy = 0; m_nb = 0; m_acc = '0; m_cur_v = 0; m_cur = '0; m_q.delete();
  endtask

  task automatic model_update();
    bit rdy;
    rdy = m_ready();
    if (rst) begin
      model_clear();
      m_err = 0;
      return;
    end
    if (bus.in_pad_valid && m_busy) m_err = 1;
    if (flush) begin
      model_clear();
      return;
    end
    if (m_busy) begin
      if (bus.in_core_ready) m_busy = 0;
    end else if (bus.in_pad_valid) begin
      if (m_nb == 0) m_op = bus.in_pad_opcode;
      m_acc[m_nb*8 +: 8] = bus.in_pad_data;
      m_nb++;
      if (m_nb == 4) begin
        m_busy = 1; m_word = m_acc; m_nb = 0;
      end
    end
    if (rdy && bus.out_core_valid)
      for (int k = 0; k < 4; k++) m_q.push_back({(k == 3), bus.out_core_data[k*8 +: 8]});
    if (m_q.size() > 0) begin
      m_cur = m_q.pop_front(); m_cur_v = 1;
    end else begin
      m_cur_v = 0;
    end
  endtask

  task automatic check_all();
    chk("in_pad_busy", bus.in_pad_busy, m_busy);
    chk("in_core_valid", bus.in_core_valid, m_busy);
    if (m_busy) begin
      chk("in_core_data", bus.in_core_data, m_word);
      chk("in_core_opcode", bus.in_core_opcode, m_op);
    end
    chk("err_overflow", err, m_err);
    chk("out_core_ready", bus.out_core_ready, m_ready());
    chk("out_pad_valid", bus.out_pad_valid, m_cur_v);
    chk("out_pad_data", bus.out_pad_data, m_cur_v ? m_cur[7:0] : 8'h00);
    chk("out_pad_last", bus.out_pad_last, m_cur_v ? m_cur[8] : 1'b0);
`ifdef IO_SERDES_OUT_PARITY_EN
    chk("out_pad_parity", par, m_cur_v ? ^m_cur[7:0] : 1'b0);
`endif
  endtask

  // One clock: check at the falling edge, advance the model, then return
  // just after the rising edge so the caller can drive the next inputs.
  task automatic step();
    @(negedge clk);
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic [3:0] op);
    bus.in_pad_valid = 1'b1; bus.in_pad_data = d; bus.in_pad_opcode = op;
    step();
    bus.in_pad_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_pad_data = '0; bus.in_pad_opcode = '0; bus.in_pad_valid = 1'b0;
    bus.in_core_ready = 1'b0; bus.out_core_data = '0; bus.out_core_valid = 1'b0;
    model_clear(); m_err = 0; m_word = '0; m_op = '0;
    repeat (3) step();
    chk("rst_ready", bus.out_core_ready, 1'b1);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    step();

    // Basic assembly, opcode from beat 0 only
    bus.in_core_ready = 1'b1;
    beat(8'h11, 4'h5); beat(8'h22, 4'hA); beat(8'h33, 4'hA); beat(8'h44, 4'hA);
    chk("tp1_valid", bus.in_core_valid, 1'b1);
    chk("tp1_data", bus.in_core_data, 32'h4433_2211);
    chk("tp1_op", bus.in_core_opcode, 4'h5);
    step();
    chk("tp1_one_cycle", bus.in_core_valid, 1'b0);

    // Back-pressure with beats kept coming
    bus.in_core_ready = 1'b0;
    beat(8'hA1, 4'h3); beat(8'hB2, 4'h0); beat(8'hC3, 4'h0); beat(8'hD4, 4'h0);
    bus.in_pad_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_pad_data = 8'($urandom);
      step();
    end
    chk("tp2_busy", bus.in_pad_busy, 1'b1);
    chk("tp2_data", bus.in_core_data, 32'hD4C3_B2A1);
    chk("tp2_err", err, 1'b1);
    bus.in_pad_valid = 1'b0; bus.in_core_ready = 1'b1;
    step(); step();
    beat(8'h55, 4'h6); beat(8'h66, 4'h1); beat(8'h77, 4'h1); beat(8'h88, 4'h1);
    chk("tp2_next", bus.in_core_data, 32'h8877_6655);
    step();

    // Continuous output stream
    bus.out_core_data = 32'hDEAD_BEEF; bus.out_core_valid = 1'b1;
    repeat (12) step();
    bus.out_core_valid = 1'b0;
    repeat (5) step();

    // Flush mid-word on the input path
    beat(8'hE0, 4'h2); beat(8'hE1, 4'h2);
    flush = 1'b1; step(); flush = 1'b0;
    beat(8'h01, 4'h9); beat(8'h02, 4'h0); beat(8'h03, 4'h0); beat(8'h04, 4'h0);
    chk("tp4_data", bus.in_core_data, 32'h0403_0201);
    chk("tp4_err", err, 1'b1);
    step();

    // Hard reset during serialisation
    bus.out_core_data = 32'h1234_0307; bus.out_core_valid = 1'b1;
    step();
    bus.out_core_valid = 1'b0;
    step(); step();
    rst = 1'b1; step();
    chk("tp5_valid", bus.out_pad_valid, 1'b0);
    chk("tp5_ready", bus.out_core_ready, 1'b1);
    chk("tp5_err", err, 1'b0);
    rst = 1'b0;
    step();

    // Parity-friendly word: beats 07, 03, 34, 12
    bus.out_core_data = 32'h1234_0307; bus.out_core_valid = 1'b1;
    step();
    bus.out_core_valid = 1'b0;
    repeat (6) step();

    // Random traffic on both paths
    for (int i = 0; i < 4000; i++) begin
      bus.in_pad_valid   = ($urandom_range(0, 3) != 0);
      bus.in_pad_data    = 8'($urandom);
      bus.in_pad_opcode  = 4'($urandom);
      bus.in_core_ready  = ($urandom_range(0, 2) != 0);
      bus.out_core_valid = ($urandom_range(0, 1) != 0);
      bus.out_core_data  = $urandom;
      flush = ($urandom_range(0, 99) == 0);
      rst   = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0;
    bus.in_pad_valid = 1'b0; bus.out_core_valid = 1'b0;
    repeat (8) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
